// File: rtl/apb_mem_slave.sv
// apb_mem_slave -- APB word-addressed memory slave with a fixed number of
// access-phase wait states, an out-of-range error response and abort on a
// PSEL drop while waiting.
//
// Build option: define APB_MEM_PSTRB_EN to add the PSTRB port and byte-lane
// write masking. Without it every write updates the whole word.
//
// Timing summary (edge T = first edge seeing PSEL=1 and PENABLE=1 in IDLE):
//   WAIT_CYCLES = 0 : IDLE --T--> RESP, memory updated at edge T.
//   WAIT_CYCLES = N : IDLE --T--> WAIT (counter N-1) ... --T+N--> RESP.
//   RESP always lasts one cycle (PREADY=1) and then returns to IDLE.
module apb_mem_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_MEM_PSTRB_EN
  input  logic [DATA_W/8-1:0] PSTRB,
`endif
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = 4;

  // Value loaded into the wait counter when leaving IDLE; the counter reaching
  // zero marks the last WAIT cycle.
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : {CNT_W{1'b0}};

  // One extra bit so DEPTH = 2**ADDR_W is representable and every address
  // compares correctly without wrapping.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  localparam bit HAS_WAIT = (WAIT_CYCLES > 0);

  // ---------------------------------------------------------------------------
  // Types and state
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q;
  state_e              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;

  // Transfer attributes captured at edge T, used while waiting.
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;

  // Registered bus outputs and their next values.
  logic [DATA_W-1:0]   prdata_q;
  logic [DATA_W-1:0]   prdata_d;
  logic                pready_q;
  logic                pready_d;
  logic                pslverr_q;
  logic                pslverr_d;

  // Storage; deliberately never reset.
  logic [DATA_W-1:0]   mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [STRB_W-1:0]   live_strb_s;
  logic                start_s;
  logic                go_resp_s;
  logic [ADDR_W-1:0]   eff_addr_s;
  logic                eff_write_s;
  logic [DATA_W-1:0]   eff_wdata_s;
  logic [STRB_W-1:0]   eff_strb_s;
  logic                eff_err_s;
  logic [IDX_W-1:0]    eff_idx_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic [DATA_W-1:0]   wmask_s;
  logic [DATA_W-1:0]   wmerge_s;
  logic                mem_we_s;

  // Expand one strobe bit per byte lane into a full-width bit mask.
  function automatic logic [DATA_W-1:0] strb_to_mask(input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] mask;
    mask = {DATA_W{1'b0}};
    for (int lane = 0; lane < STRB_W; lane++) begin
      mask[lane*8 +: 8] = {8{strb[lane]}};
    end
    return mask;
  endfunction

`ifdef APB_MEM_PSTRB_EN
  assign live_strb_s = PSTRB;
`else
  assign live_strb_s = {STRB_W{1'b1}};
`endif

  assign start_s = (state_q == ST_IDLE) && PSEL && PENABLE;

  // Pick the transfer attributes: live bus values in IDLE (needed when a
  // zero-wait transfer completes on edge T itself), the captured copy otherwise.
  always_comb begin
    if (state_q == ST_IDLE) begin
      eff_addr_s  = PADDR;
      eff_write_s = PWRITE;
      eff_wdata_s = PWDATA;
      eff_strb_s  = live_strb_s;
    end else begin
      eff_addr_s  = addr_q;
      eff_write_s = write_q;
      eff_wdata_s = wdata_q;
      eff_strb_s  = strb_q;
    end
  end

  // Out-of-range addresses are rejected, never folded onto a valid word.
  assign eff_err_s = ({1'b0, eff_addr_s} >= DEPTH_LIM);
  assign eff_idx_s = eff_addr_s[IDX_W-1:0];
  assign rd_word_s = mem[eff_idx_s];
  assign wmask_s   = strb_to_mask(eff_strb_s);
  assign wmerge_s  = (rd_word_s & ~wmask_s) | (eff_wdata_s & wmask_s);

  // ---------------------------------------------------------------------------
  // FSM process 1: state and wait-counter registers
  // ---------------------------------------------------------------------------
  // Advance the FSM and wait counter; reset forces IDLE from any state.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  // Decide the next state, counter value and whether this edge completes a transfer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    go_resp_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          if (HAS_WAIT) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d   = ST_RESP;
            cnt_d     = {CNT_W{1'b0}};
            go_resp_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          // Master abandoned the transfer: drop it without any side effect.
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d   = ST_RESP;
          cnt_d     = {CNT_W{1'b0}};
          go_resp_s = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RESP: begin
        // Bus activity is ignored here; the response lasts exactly one cycle.
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: output / side-effect logic
  // ---------------------------------------------------------------------------
  // Compute next PREADY/PSLVERR/PRDATA and the memory write enable for the completing edge.
  always_comb begin
    pready_d  = go_resp_s;
    pslverr_d = go_resp_s && eff_err_s;
    prdata_d  = prdata_q;
    mem_we_s  = 1'b0;
    if (go_resp_s) begin
      if (eff_write_s) begin
        // Writes never disturb the last read value; reset kills the write.
        mem_we_s = !eff_err_s && !PRESET;
        prdata_d = prdata_q;
      end else if (eff_err_s) begin
        prdata_d = {DATA_W{1'b0}};
      end else begin
        prdata_d = rd_word_s;
      end
    end else begin
      mem_we_s = 1'b0;
      prdata_d = prdata_q;
    end
  end

  // Register the bus outputs so PREADY, PSLVERR and PRDATA change only on clock edges.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= {DATA_W{1'b0}};
    end else begin
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Capture address, direction, data and strobes at edge T for use during WAIT.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      addr_q  <= {ADDR_W{1'b0}};
      write_q <= 1'b0;
      wdata_q <= {DATA_W{1'b0}};
      strb_q  <= {STRB_W{1'b0}};
    end else if (start_s) begin
      addr_q  <= PADDR;
      write_q <= PWRITE;
      wdata_q <= PWDATA;
      strb_q  <= live_strb_s;
    end else begin
      addr_q  <= addr_q;
      write_q <= write_q;
      wdata_q <= wdata_q;
      strb_q  <= strb_q;
    end
  end

  // Update the addressed word with the lane-merged write data.
  always_ff @(posedge PCLK) begin
    if (mem_we_s) begin
      mem[eff_idx_s] <= wmerge_s;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave -- self-checking bench for apb_mem_slave.
// Instance A: WAIT_CYCLES=2, instance B: WAIT_CYCLES=0. Define APB_MEM_PSTRB_EN
// to also exercise byte-lane strobes.
module tb_apb_mem_slave;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 256;
  localparam int STRB_W = DATA_W / 8;
  localparam int WC_A   = 2;
  localparam int WC_B   = 0;

  logic PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  logic              preset;
  logic              psel    [2];
  logic              penable [2];
  logic              pwrite  [2];
  logic [ADDR_W-1:0] paddr   [2];
  logic [DATA_W-1:0] pwdata  [2];
`ifdef APB_MEM_PSTRB_EN
  logic [STRB_W-1:0] pstrb   [2];
`endif
  logic [DATA_W-1:0] prdata_a, prdata_b;
  logic              pready_a, pready_b, pslverr_a, pslverr_b;

  apb_mem_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WC_A)) dut_a (
    .PCLK(PCLK), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]),
`ifdef APB_MEM_PSTRB_EN
    .PSTRB(pstrb[0]),
`endif
    .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a));

  apb_mem_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WC_B)) dut_b (
    .PCLK(PCLK), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]),
`ifdef APB_MEM_PSTRB_EN
    .PSTRB(pstrb[1]),
`endif
    .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: word array per instance plus the PRDATA value the bus should hold.
  logic [DATA_W-1:0] model_mem [2][DEPTH];
  logic [DATA_W-1:0] last_rd   [2];

  function automatic void model_write(input int which, input logic [ADDR_W-1:0] addr,
                                      input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] strb);
    if (int'(addr) < DEPTH) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb[b]) model_mem[which][addr][b*8 +: 8] = data[b*8 +: 8];
      end
    end
  endfunction

  function automatic logic [DATA_W-1:0] model_read(input int which, input logic [ADDR_W-1:0] addr);
    if (int'(addr) < DEPTH) return model_mem[which][addr];
    return '0;
  endfunction

  function automatic logic model_err(input logic [ADDR_W-1:0] addr);
    return (int'(addr) >= DEPTH);
  endfunction

  // One complete APB transfer: setup cycle, access phase until PREADY (bounded).
  // lat = number of edges from edge T (inclusive) until PREADY is seen.
  task automatic xfer(input int which, input logic wr, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] data, output logic [DATA_W-1:0] rdata,
                      output logic err, output int lat, output logic early_err, output logic timeout);
    logic rdy;
    lat = 0; early_err = 1'b0; timeout = 1'b0; rdy = 1'b0;
    @(posedge PCLK); #1;
    psel[which] = 1'b1; penable[which] = 1'b0; pwrite[which] = wr;
    paddr[which] = addr; pwdata[which] = data;
    @(posedge PCLK); #1;
    penable[which] = 1'b1;
    while (!rdy && !timeout) begin
      @(posedge PCLK); #1;
      lat++;
      rdy = (which == 0) ? pready_a : pready_b;
      if (!rdy && ((which == 0) ? pslverr_a : pslverr_b)) early_err = 1'b1;
      if (lat > 40) timeout = 1'b1;
    end
    rdata = (which == 0) ? prdata_a : prdata_b;
    err   = (which == 0) ? pslverr_a : pslverr_b;
  endtask

  task automatic bus_idle(input int which);
    @(posedge PCLK); #1;
    psel[which] = 1'b0; penable[which] = 1'b0;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 preset = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    n_checks++; if (pready_a !== 1'b0 || pready_b !== 1'b0) begin n_fail++; $display("FAIL reset_pready: got %b/%b want 0/0", pready_a, pready_b); end
    n_checks++; if (pslverr_a !== 1'b0 || pslverr_b !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr: got %b/%b want 0/0", pslverr_a, pslverr_b); end
    n_checks++; if (prdata_a !== 32'h0 || prdata_b !== 32'h0) begin n_fail++; $display("FAIL reset_prdata: got %h/%h want 0", prdata_a, prdata_b); end
  endtask

  // Write then read with checks of latency, error flag and PRDATA behaviour on writes.
  task automatic test_basic();
    logic [DATA_W-1:0] rd; logic err, early, to; int lat;
    xfer(0, 1'b1, 10'h010, 32'hA5A51234, rd, err, lat, early, to);
    model_write(0, 10'h010, 32'hA5A51234, '1);
    n_checks++; if (to !== 1'b0 || lat != WC_A + 1) begin n_fail++; $display("FAIL basic_wr_latency: got %0d (timeout %b) want %0d", lat, to, WC_A + 1); end
    n_checks++; if (err !== 1'b0 || early !== 1'b0) begin n_fail++; $display("FAIL basic_wr_err: got %b early %b want 0", err, early); end
    n_checks++; if (rd !== last_rd[0]) begin n_fail++; $display("FAIL basic_wr_prdata_hold: got %h want %h", rd, last_rd[0]); end
    xfer(0, 1'b0, 10'h010, 32'h0, rd, err, lat, early, to);
    last_rd[0] = model_read(0, 10'h010);
    n_checks++; if (rd !== 32'hA5A51234) begin n_fail++; $display("FAIL basic_rd_data: got %h want a5a51234", rd); end
    n_checks++; if (to !== 1'b0 || lat != WC_A + 1) begin n_fail++; $display("FAIL basic_rd_latency: got %0d want %0d", lat, WC_A + 1); end
    n_checks++; if (err !== 1'b0 || early !== 1'b0) begin n_fail++; $display("FAIL basic_rd_err: got %b early %b want 0", err, early); end
    bus_idle(0);
  endtask

  // Out-of-range accesses: error response, no write, no aliasing; DEPTH-1 still valid.
  task automatic test_error();
    logic [DATA_W-1:0] rd; logic err, early, to; int lat;
    xfer(0, 1'b1, 10'h000, 32'h0BADF00D, rd, err, lat, early, to);
    model_write(0, 10'h000, 32'h0BADF00D, '1);
    xfer(0, 1'b1, 10'h0FF, 32'h5EED0FF0, rd, err, lat, early, to);
    model_write(0, 10'h0FF, 32'h5EED0FF0, '1);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_last_word_wr: got %b want 0", err); end
    xfer(0, 1'b0, 10'h100, 32'h0, rd, err, lat, early, to);
    last_rd[0] = '0;
    n_checks++; if (err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_rd_100: got err %b data %h want 1/0", err, rd); end
    n_checks++; if (lat != WC_A + 1 || early !== 1'b0) begin n_fail++; $display("FAIL err_rd_timing: got lat %0d early %b want %0d/0", lat, early, WC_A + 1); end
    xfer(0, 1'b1, 10'h100, 32'hDEADBEEF, rd, err, lat, early, to);
    n_checks++; if (err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_wr_100: got err %b data %h want 1/0", err, rd); end
    xfer(0, 1'b0, 10'h3FF, 32'h0, rd, err, lat, early, to);
    n_checks++; if (err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_rd_3ff: got err %b data %h want 1/0", err, rd); end
    xfer(0, 1'b0, 10'h000, 32'h0, rd, err, lat, early, to);
    last_rd[0] = model_read(0, 10'h000);
    n_checks++; if (err !== 1'b0 || rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL err_no_alias_000: got err %b data %h want 0/0badf00d", err, rd); end
    xfer(0, 1'b0, 10'h0FF, 32'h0, rd, err, lat, early, to);
    last_rd[0] = model_read(0, 10'h0FF);
    n_checks++; if (err !== 1'b0 || rd !== 32'h5EED0FF0) begin n_fail++; $display("FAIL err_last_word_rd: got err %b data %h want 0/5eed0ff0", err, rd); end
    bus_idle(0);
  endtask

  // PSEL dropped during WAIT: no response, no write, next transfer normal.
  task automatic test_abort();
    logic [DATA_W-1:0] rd; logic err, early, to; int lat; logic saw_ready;
    xfer(0, 1'b1, 10'h020, 32'h22222222, rd, err, lat, early, to);
    model_write(0, 10'h020, 32'h22222222, '1);
    bus_idle(0);
    @(posedge PCLK); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 10'h020; pwdata[0] = 32'h11111111;
    @(posedge PCLK); #1;
    penable[0] = 1'b1;
    @(posedge PCLK); #1;
    saw_ready = pready_a;
    psel[0] = 1'b0; penable[0] = 1'b0;
    repeat (6) begin
      @(posedge PCLK); #1;
      if (pready_a) saw_ready = 1'b1;
    end
    n_checks++; if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL abort_pready: got %b want 0", saw_ready); end
    n_checks++; if (prdata_a !== last_rd[0]) begin n_fail++; $display("FAIL abort_prdata: got %h want %h", prdata_a, last_rd[0]); end
    xfer(0, 1'b0, 10'h020, 32'h0, rd, err, lat, early, to);
    last_rd[0] = model_read(0, 10'h020);
    n_checks++; if (rd !== 32'h22222222 || err !== 1'b0) begin n_fail++; $display("FAIL abort_old_value: got %h err %b want 22222222/0", rd, err); end
    n_checks++; if (lat != WC_A + 1 || to !== 1'b0) begin n_fail++; $display("FAIL abort_next_latency: got %0d want %0d", lat, WC_A + 1); end
    bus_idle(0);
  endtask

  // Reset pulse during the last WAIT cycle of a write to 0x010.
  task automatic test_reset_in_wait();
    logic [DATA_W-1:0] rd; logic err, early, to; int lat; logic saw_ready;
    @(posedge PCLK); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 10'h010; pwdata[0] = 32'h77777777;
    @(posedge PCLK); #1;
    penable[0] = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    preset = 1'b1;
    @(posedge PCLK); #1;
    preset = 1'b0;
    psel[0] = 1'b0; penable[0] = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    n_checks++; if (pready_a !== 1'b0 || pslverr_a !== 1'b0) begin n_fail++; $display("FAIL rstwait_flags: got %b/%b want 0/0", pready_a, pslverr_a); end
    n_checks++; if (prdata_a !== 32'h0) begin n_fail++; $display("FAIL rstwait_prdata: got %h want 0", prdata_a); end
    saw_ready = 1'b0;
    repeat (4) begin
      @(posedge PCLK); #1;
      if (pready_a) saw_ready = 1'b1;
    end
    n_checks++; if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL rstwait_idle: got pready %b want 0", saw_ready); end
    xfer(0, 1'b0, 10'h010, 32'h0, rd, err, lat, early, to);
    last_rd[0] = model_read(0, 10'h010);
    n_checks++; if (rd !== 32'hA5A51234) begin n_fail++; $display("FAIL rstwait_keep_010: got %h want a5a51234", rd); end
    n_checks++; if (lat != WC_A + 1 || err !== 1'b0) begin n_fail++; $display("FAIL rstwait_next_xfer: got lat %0d err %b want %0d/0", lat, err, WC_A + 1); end
    bus_idle(0);
  endtask

`ifdef APB_MEM_PSTRB_EN
  // Byte-lane strobes, including an all-zero strobe.
  task automatic test_strobe();
    logic [DATA_W-1:0] rd; logic err, early, to; int lat;
    pstrb[0] = 4'b0010;
    xfer(0, 1'b1, 10'h010, 32'hFFFFFFFF, rd, err, lat, early, to);
    model_write(0, 10'h010, 32'hFFFFFFFF, 4'b0010);
    pstrb[0] = 4'b0000;
    xfer(0, 1'b1, 10'h010, 32'h00000000, rd, err, lat, early, to);
    model_write(0, 10'h010, 32'h00000000, 4'b0000);
    n_checks++; if (err !== 1'b0 || lat != WC_A + 1) begin n_fail++; $display("FAIL strobe_zero_done: got err %b lat %0d", err, lat); end
    pstrb[0] = 4'b1111;
    xfer(0, 1'b0, 10'h010, 32'h0, rd, err, lat, early, to);
    last_rd[0] = model_read(0, 10'h010);
    n_checks++; if (rd !== 32'hA5A5FF34) begin n_fail++; $display("FAIL strobe_merge: got %h want a5a5ff34", rd); end
    bus_idle(0);
  endtask
`endif

  // Randomised mix of reads/writes, valid and out-of-range, against the model.
  task automatic test_random();
    logic [DATA_W-1:0] rd, d, exp; logic err, early, to, wr; int lat, sel;
    logic [ADDR_W-1:0] a;
    logic [STRB_W-1:0] s;
    s = '1;
`ifdef APB_MEM_PSTRB_EN
    pstrb[0] = 4'b1111;
`endif
    for (int i = 0; i < 33; i++) begin
      a = (i == 32) ? 10'h0FF : ADDR_W'(i);
      d = $urandom;
      xfer(0, 1'b1, a, d, rd, err, lat, early, to);
      model_write(0, a, d, '1);
    end
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = ADDR_W'($urandom_range(DEPTH, 1023));
      else if (sel == 1) a = 10'h0FF;
      else               a = ADDR_W'($urandom_range(0, 31));
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
`ifdef APB_MEM_PSTRB_EN
      s = STRB_W'($urandom_range(0, 15));
      pstrb[0] = s;
`endif
      xfer(0, wr, a, d, rd, err, lat, early, to);
      n_checks++; if (err !== model_err(a) || lat != WC_A + 1 || early !== 1'b0 || to !== 1'b0) begin
        n_fail++; $display("FAIL rand_resp[%0d] addr %h: got err %b lat %0d early %b want err %b lat %0d", i, a, err, lat, early, model_err(a), WC_A + 1);
      end
      if (wr) begin
        model_write(0, a, d, s);
        exp = last_rd[0];
      end else begin
        exp = model_read(0, a);
        last_rd[0] = exp;
      end
      n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL rand_prdata[%0d] addr %h wr %b: got %h want %h", i, a, wr, rd, exp); end
    end
`ifdef APB_MEM_PSTRB_EN
    pstrb[0] = 4'b1111;
`endif
    bus_idle(0);
  endtask

  // Zero-wait instance: back-to-back writes then back-to-back reads.
  task automatic test_back_to_back();
    logic [DATA_W-1:0] rd, d1, d2; logic err, early, to; int lat1, lat2;
    d1 = $urandom; d2 = $urandom;
    xfer(1, 1'b1, 10'h001, d1, rd, err, lat1, early, to);
    model_write(1, 10'h001, d1, '1);
    xfer(1, 1'b1, 10'h002, d2, rd, err, lat2, early, to);
    model_write(1, 10'h002, d2, '1);
    n_checks++; if (lat1 != WC_B + 1 || lat2 != WC_B + 1) begin n_fail++; $display("FAIL b2b_wr_latency: got %0d/%0d want %0d", lat1, lat2, WC_B + 1); end
    n_checks++; if (err !== 1'b0 || rd !== last_rd[1]) begin n_fail++; $display("FAIL b2b_wr_resp: got err %b data %h want 0/%h", err, rd, last_rd[1]); end
    xfer(1, 1'b0, 10'h001, 32'h0, rd, err, lat1, early, to);
    n_checks++; if (rd !== model_read(1, 10'h001)) begin n_fail++; $display("FAIL b2b_rd_001: got %h want %h", rd, model_read(1, 10'h001)); end
    xfer(1, 1'b0, 10'h002, 32'h0, rd, err, lat2, early, to);
    last_rd[1] = model_read(1, 10'h002);
    n_checks++; if (rd !== last_rd[1]) begin n_fail++; $display("FAIL b2b_rd_002: got %h want %h", rd, last_rd[1]); end
    n_checks++; if (lat1 != WC_B + 1 || lat2 != WC_B + 1 || err !== 1'b0) begin n_fail++; $display("FAIL b2b_rd_latency: got %0d/%0d err %b", lat1, lat2, err); end
    bus_idle(1);
  endtask

  initial begin
    preset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0; paddr[k] = '0; pwdata[k] = '0;
`ifdef APB_MEM_PSTRB_EN
      pstrb[k] = '1;
`endif
      last_rd[k] = '0;
    end
    test_reset();
    test_basic();
    test_error();
    test_abort();
    test_reset_in_wait();
`ifdef APB_MEM_PSTRB_EN
    test_strobe();
`endif
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width in bits, a multiple of 8, range 8..64.
REQ-002 SHALL have parameter ADDR_W, default 10: PADDR width in bits (word address).
REQ-003 SHALL have parameter DEPTH, default 256: number of storage words, 1 <= DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0: extra access-phase wait states, range 0..15.
REQ-005 SHALL have port PCLK, input, 1 bit: the single clock; all logic acts on its rising edge.
REQ-006 SHALL have port PRESET, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port PSEL, input, 1 bit: slave select.
REQ-008 SHALL have port PENABLE, input, 1 bit: access-phase indicator.
REQ-009 SHALL have port PWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port PADDR, input, ADDR_W bits: word address.
REQ-011 SHALL have port PWDATA, input, DATA_W bits: write data.
REQ-012 SHALL have port PSTRB, input, DATA_W/8 bits, only under APB_MEM_PSTRB_EN: byte-lane write strobes.
REQ-013 SHALL have port PRDATA, output, DATA_W bits: registered read data.
REQ-014 SHALL have port PREADY, output, 1 bit: registered transfer-complete flag.
REQ-015 SHALL have port PSLVERR, output, 1 bit: error flag, valid only while PREADY=1.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-017 SHALL capture PADDR, PWRITE, PWDATA (and PSTRB) in IDLE when PSEL=1 and PENABLE=1 at a clock edge (edge T).
- From there it SHALL go to RESP if WAIT_CYCLES=0.
- Otherwise it SHALL go to WAIT and load the wait counter with WAIT_CYCLES-1.
REQ-018 SHALL, in WAIT, decrement the counter each edge and go to RESP at the edge where the counter equals 0.
- PREADY therefore first reads 1 after edge T+WAIT_CYCLES.
- The access phase lasts WAIT_CYCLES+2 cycles.
REQ-019 SHALL hold PREADY=1 in RESP for exactly one cycle, then return to IDLE with PREADY=0.
- A new setup phase in the following cycle SHALL be accepted normally (back-to-back transfers).
REQ-020 SHALL flag an error when the captured address is >= DEPTH.
- PSLVERR=1 in RESP.
- No memory write.
- PRDATA=0 for reads.
- The address SHALL NOT wrap or alias.
REQ-021 SHALL, on a valid write, update memory at the edge entering RESP; PSLVERR=0.
REQ-022 SHALL, on a valid read, load PRDATA at the edge entering RESP and hold it until the next read completes; writes leave PRDATA unchanged.
REQ-023 SHALL treat PSEL=0 in WAIT as an abort: return to IDLE, no write, PRDATA unchanged, PREADY stays 0.
REQ-024 SHALL ignore PSEL/PENABLE changes while in RESP.
REQ-025 SHALL drive PSLVERR=0 in all states other than RESP.

Reset
REQ-026 SHALL, while PRESET=1 at an edge, force state to IDLE and drive PREADY=0, PSLVERR=0, PRDATA=0 and wait counter 0; this includes reset in WAIT or RESP.
REQ-027 SHALL NOT clear memory contents on reset, and SHALL suppress any in-flight write.

Configuration
REQ-028 SHALL use macro APB_MEM_PSTRB_EN to select the write-strobe behaviour.
- Defined: the PSTRB port exists and a valid write updates only the byte lanes whose PSTRB bit is 1; PSTRB=0 writes complete normally with no change.
- Undefined: the PSTRB port is absent and every write updates all lanes.

Verification (DATA_W=32, ADDR_W=10, DEPTH=256, WAIT_CYCLES=2 unless stated)
REQ-029 SHALL cover: write 0xA5A51234 to 0x010, then read 0x010 -> PRDATA=0xA5A51234, PREADY first 1 after edge T+2, PSLVERR=0.
REQ-030 SHALL cover: read 0x100, then write 0xDEADBEEF to 0x100 -> PSLVERR=1 on both, PRDATA=0, location 0x000 unchanged.
REQ-031 SHALL cover (APB_MEM_PSTRB_EN defined): write 0xFFFFFFFF with PSTRB=4'b0010 to 0x010 holding 0xA5A51234 -> subsequent read returns 0xA5A5FF34.
REQ-032 SHALL cover: drop PSEL during WAIT of a write of 0x11111111 to 0x020 -> PREADY never 1, 0x020 keeps its old value, the next transfer completes normally.
REQ-033 SHALL cover: PRESET=1 for one cycle during WAIT -> next cycle PREADY=0, PSLVERR=0, PRDATA=0, state IDLE; earlier data at 0x010 still reads 0xA5A51234.
REQ-034 SHALL cover (WAIT_CYCLES=0): two back-to-back writes to 0x001 and 0x002 -> each access phase lasts 2 cycles, and both values read back.
